// File: rtl/gray_pkg.sv
// Gray/binary conversion helpers and the default board divider for slow-LED blocks.
// Functions work on GRAY_W-bit values; callers zero-extend in and truncate out.
package gray_pkg;

    localparam int GRAY_W      = 32;
    localparam int BOARD_DIV   = 50_000_000;

    function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
        logic [GRAY_W-1:0] b;
        b[GRAY_W-1] = g[GRAY_W-1];
        for (int i = GRAY_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/clk_en_prescaler.sv
// Clock-enable prescaler: registered one-cycle tick once every DIV enabled cycles.
// Latency: tick asserts the cycle after the enabled cycle where the count hits DIV-1.
// Backpressure: en low freezes the count and suppresses tick; clr restarts from zero.
module clk_en_prescaler #(
    parameter int DIV   = 4,
    parameter int DIV_W = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + DIV_W'(1);
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/gray_counter_ctrl.sv
// N-bit Gray counter with prescaled stepping, up/down, wrap or saturate, and parallel load.
// Latency: outputs registered; a step shows one cycle after the tick-high cycle.
// Backpressure: en low freezes prescaler and count; load wins over a coincident step.
module gray_counter_ctrl
    import gray_pkg::*;
#(
    parameter int N     = 4,
    parameter int DIV   = BOARD_DIV,
    parameter int DIV_W = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         dir,
    input  logic         sat,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] leds,
    output logic [N-1:0] bin_out,
    output logic         tick,
    output logic         tc
);

    localparam logic [N-1:0] TOP = '1;

    logic [N-1:0] step_val;
    logic         step_tc;
    logic [N-1:0] load_bin;

    // Loading also restarts the prescaler so a pending tick cannot fire a stale step.
    clk_en_prescaler #(
        .DIV   (DIV),
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load),
        .tick (tick)
    );

    assign load_bin = N'(gray2bin(GRAY_W'(load_val)));

    always_comb begin
        step_val = bin_out;
        step_tc  = 1'b0;
        if (dir) begin
            if (bin_out == TOP) begin
                step_tc  = 1'b1;
                step_val = sat ? bin_out : '0;
            end else begin
                step_val = bin_out + N'(1);
            end
        end else begin
            if (bin_out == '0) begin
                step_tc  = 1'b1;
                step_val = sat ? bin_out : TOP;
            end else begin
                step_val = bin_out - N'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_out <= '0;
            leds    <= '0;
            tc      <= 1'b0;
        end else if (load) begin
            bin_out <= load_bin;
            leds    <= load_val;
            tc      <= 1'b0;
        end else if (tick && en) begin
            bin_out <= step_val;
            leds    <= N'(bin2gray(GRAY_W'(step_val)));
            tc      <= step_tc;
        end else begin
            tc      <= 1'b0;
        end
    end

endmodule

// File: doc/gray_counter_ctrl.md
Name: gray_counter_ctrl

Overview:
- Parametrised N-bit Gray-code counter with a built-in clock-enable prescaler, up/down direction, wrap or saturate mode, synchronous parallel load and a terminal-count pulse.
- Next-generation core for the LED Gray counter system. Drives the board LEDs directly; slow enough to be visible with the default divider.
- Behaviour is fully parametrised so simulation benches can run with a small DIV.

Parameters:
- N, 4, counter width in bits (N >= 2).
- DIV, 50_000_000, prescaler divide ratio: one count step every DIV enabled clk cycles (DIV >= 1).
- DIV_W, $clog2(DIV) (min 1), prescaler counter width; derived, not overridden.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  prescaler/count enable; low freezes the prescaler and the count.
- dir  in  1  1 = count up, 0 = count down.
- sat  in  1  1 = saturate at end of range, 0 = wrap around.
- load  in  1  synchronous load strobe.
- load_val  in  N  Gray-coded value to load.
- leds  out  N  current count, Gray code, registered.
- bin_out  out  N  current count, binary, registered.
- tick  out  1  registered one-cycle pulse, one per DIV enabled cycles.
- tc  out  1  registered one-cycle terminal-count pulse.

Behaviour:
- Reset (rst=1 at an edge): prescaler=0, binary count=0, leds=0, bin_out=0, tick=0, tc=0. Reset overrides all other inputs.
- Priority at each edge: rst > load > step.
- Prescaler: when en=1 and the prescaler equals DIV-1, it returns to 0 and tick=1 on the following cycle. Otherwise, when en=1, it increments and tick=0. When en=0, it holds and tick=0.
- DIV=1: tick is high on every cycle following an enabled cycle.
- Step: at an edge where tick=1, load=0 and en=1, the count advances one position in direction dir. leds and bin_out show the new value in the next cycle, i.e. one cycle after the tick-high cycle.
- A tick is discarded if en drops in the tick-high cycle.
- Gray encoding: leds = b ^ (b >> 1), where b is the internal binary count. Every step changes exactly one leds bit, including the wrap step.
- Wrap (sat=0):
  - up from 2^N-1 goes to 0;
  - down from 0 goes to 2^N-1;
  - tc=1 for one cycle, coincident with the wrapped value appearing.
- Saturate (sat=1):
  - up at 2^N-1 or down at 0 leaves the count unchanged;
  - tc=1 for one cycle on each such step attempt.
- Load:
  - load=1 at an edge converts load_val to binary (b[i] = XOR of load_val[N-1:i]) and stores it;
  - leds=load_val and bin_out=converted value in the next cycle;
  - the prescaler is cleared to 0 and the pending tick is dropped;
  - the load is independent of en; tc=0.
- Load and tick in the same cycle: load wins and the step is lost.
- dir and sat are sampled only at step edges and may change at any time.
- Reset mid-prescale or mid-count: everything returns to reset values at that edge. Counting resumes DIV enabled cycles after rst deasserts.
- No combinational path from any input to any output.

Decomposition:
- Shared package gray_pkg: functions bin2gray(N) and gray2bin(N), and the localparam for the default board divider (50_000_000).
- Sub-module clk_en_prescaler (parameters DIV, DIV_W; ports clk, rst, en, clr, tick). It is reusable by other slow-LED blocks.
- gray_counter_ctrl instantiates it and holds the count, load and tc logic.

Test Plan (N=4, DIV=4):
- Reset: hold rst=1 for 2 cycles with en=1 and load=1 -> leds=0000, bin_out=0, tick=0, tc=0 at every edge while rst=1.
- Up count with wrap: en=1, dir=1, sat=0, run 17 ticks.
  - Required: tick every 4th cycle.
  - leds sequence 0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000,0001.
  - tc=1 only with the 1000->0000 transition; Hamming distance 1 on every step.
- Down wrap: from reset, dir=0, sat=0, one tick -> leds=1000, bin_out=15, tc=1 for one cycle. Next tick -> 1001.
- Saturate: load 1000, dir=1, sat=1, 3 ticks -> leds stays 1000, tc pulses 3 times. Then dir=0 -> 1001.
- Load mid-prescale: load_val=1010 on prescaler count 2.
  - Next cycle: leds=1010, bin_out=12.
  - Next tick arrives 4 enabled cycles later -> leds=1011.
  - Also: load coincident with tick -> loaded value shown, no step.
- Enable and reset interaction: drop en for 10 cycles mid-count -> leds and prescaler frozen, no tick. Re-enable -> the remaining prescale cycles elapse before the next step. Then assert rst at leds=0110 -> leds=0000 at the next edge.
